// File: rtl/clb_pkg.sv
// Shared definitions for the logic cluster: configuration FSM states and
// the helpers that size and lay out the serial configuration chain.
package clb_pkg;

    typedef enum logic [1:0] {
        ST_UNCFG = 2'd0,
        ST_SHIFT = 2'd1,
        ST_RUN   = 2'd2
    } cfg_state_e;

    function automatic int clb_clog2(input int v);
        int r;
        r = 0;
        for (int p = 1; p < v; p = p * 2) r++;
        return r;
    endfunction

    function automatic int sel_off(input int j, input int s);
        return j * s;
    endfunction

    function automatic int mode_off(input int k, input int s);
        return k * s;
    endfunction

    function automatic int lut_off(input int k, input int s);
        return k * s + 1;
    endfunction

    function automatic int ble_bits(input int k, input int s);
        return (1 << k) + 1 + k * s;
    endfunction

    function automatic int cfg_bits(input int k, input int n, input int s);
        return n * ble_bits(k, s);
    endfunction

endpackage

// File: rtl/ble_k.sv
// One basic logic element: K input muxes, 2^K LUT, output flip-flop and mode mux.
// Combinational path in_i -> out_o when mode=1; registered q otherwise.
module ble_k
    import clb_pkg::*;
#(
    parameter int K = 4,
    parameter int I = 10,
    parameter int N = 4,
    parameter int S = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ble_bits(K,S)-1:0]  cfg_i,
    input  logic [I-1:0]              in_i,
    input  logic [N-1:0]              fb_i,
    input  logic                      run_i,
    input  logic                      upd_i,
    input  logic                      ce_i,
    output logic                      out_o,
    output logic                      q_o
);

    localparam int LUT_W = 1 << K;

    logic [S-1:0]     sel;
    logic [K-1:0]     idx;
    logic [LUT_W-1:0] lut;
    logic             mode;
    logic             lut_out;
    logic             q_q, q_d;

    // Selects beyond I+N leave the LUT input at 0.
    always_comb begin
        idx = '0;
        sel = '0;
        for (int j = 0; j < K; j++) begin
            sel = cfg_i[sel_off(j, S) +: S];
            for (int x = 0; x < I; x++) begin
                if (sel == S'(x)) idx[j] = in_i[x];
            end
            for (int y = 0; y < N; y++) begin
                if (sel == S'(I + y)) idx[j] = fb_i[y];
            end
        end
    end

    assign lut     = cfg_i[lut_off(K, S) +: LUT_W];
    assign mode    = cfg_i[mode_off(K, S)];
    assign lut_out = lut[idx];

    always_comb begin
        q_d = q_q;
        if (!upd_i) begin
            q_d = 1'b0;
        end else if (ce_i) begin
            q_d = lut_out;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o   = q_q;
    assign out_o = run_i ? (mode ? lut_out : q_q) : 1'b0;

endmodule

// File: rtl/ble_cluster.sv
// Cluster of N BLEs configured through a serial scan chain with load-length checking.
// Chain shifts one bit per cycle; outputs are live only once a full-length load completes.
module ble_cluster
    import clb_pkg::*;
#(
    parameter int K = 4,
    parameter int N = 4,
    parameter int I = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          scan_en,
    input  logic          scan_in,
    output logic          scan_out,
    input  logic          ce,
    input  logic [I-1:0]  in,
    output logic [N-1:0]  out,
    output logic          cfg_done,
    output logic          cfg_err
);

    localparam int S        = clb_clog2(I + N);
    localparam int BLE_BITS = ble_bits(K, S);
    localparam int CFG_BITS = cfg_bits(K, N, S);
    localparam int CW       = clb_clog2(CFG_BITS + 2);

    cfg_state_e            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [CFG_BITS-1:0]   chain_q, chain_d;
    logic                  so_q, so_d;
    logic                  err_q, err_d;
    logic                  run;
    logic                  upd;
    logic [N-1:0]          q_vec;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_UNCFG;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_UNCFG, ST_RUN: begin
                if (scan_en) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (!scan_en) state_d = (cnt_q == CW'(CFG_BITS)) ? ST_RUN : ST_UNCFG;
            end
            default: state_d = ST_UNCFG;
        endcase
    end

    // A scan request in RUN keeps outputs live this cycle but clears the flops at the edge.
    always_comb begin
        run      = (state_q == ST_RUN);
        upd      = run && !scan_en;
        cfg_done = run;
    end

    always_comb begin
        cnt_d   = cnt_q;
        chain_d = chain_q;
        so_d    = so_q;
        err_d   = err_q;
        if (scan_en) begin
            chain_d = {chain_q[CFG_BITS-2:0], scan_in};
            so_d    = chain_q[CFG_BITS-1];
            if (state_q != ST_SHIFT) begin
                cnt_d = CW'(1);
            end else if (cnt_q != CW'(CFG_BITS + 1)) begin
                cnt_d = cnt_q + CW'(1);
            end
        end else if (state_q == ST_SHIFT) begin
            cnt_d = '0;
            err_d = (cnt_q != CW'(CFG_BITS));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            chain_q <= '0;
            so_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            chain_q <= chain_d;
            so_q    <= so_d;
            err_q   <= err_d;
        end
    end

    assign scan_out = so_q;
    assign cfg_err  = err_q;

    for (genvar b = 0; b < N; b++) begin : g_ble
        ble_k #(
            .K (K),
            .I (I),
            .N (N),
            .S (S)
        ) u_ble (
            .clk   (clk),
            .rst   (rst),
            .cfg_i (chain_q[b*BLE_BITS +: BLE_BITS]),
            .in_i  (in),
            .fb_i  (q_vec),
            .run_i (run),
            .upd_i (upd),
            .ce_i  (ce),
            .out_o (out[b]),
            .q_o   (q_vec[b])
        );
    end

endmodule

// File: tb/tb_ble_cluster.sv
// Randomized bench for ble_cluster with a behavioural model and literal spot checks.
module tb_ble_cluster;

    localparam int K  = 4;
    localparam int N  = 4;
    localparam int I  = 10;
    localparam int S  = 4;
    localparam int BB = 33;
    localparam int CB = 132;

    logic          clk = 1'b0;
    logic          rst, scan_en, scan_in, ce;
    logic [I-1:0]  in;
    logic [N-1:0]  out;
    logic          scan_out, cfg_done, cfg_err;

    always #5 clk = ~clk;

    ble_cluster #(.K(K), .N(N), .I(I)) dut (
        .clk      (clk),
        .rst      (rst),
        .scan_en  (scan_en),
        .scan_in  (scan_in),
        .scan_out (scan_out),
        .ce       (ce),
        .in       (in),
        .out      (out),
        .cfg_done (cfg_done),
        .cfg_err  (cfg_err)
    );

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_on = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Model: hist[p] is chain bit p (most recent shifted bit at index 0).
    bit          hist[$];
    bit          m_run, m_shift, m_err, m_so;
    int          m_cnt;
    bit [N-1:0]  m_q, m_nq;

    function automatic bit cbit(input int p);
        if (p < hist.size()) return hist[p];
        return 1'b0;
    endfunction

    function automatic int field(input int b, input int off, input int w);
        int v = 0;
        for (int i = 0; i < w; i++) v |= int'(cbit(b*BB + off + i)) << i;
        return v;
    endfunction

    function automatic bit lut_eval(input int b);
        int idx = 0;
        for (int j = 0; j < K; j++) begin
            int v = field(b, j*S, S);
            bit x = 1'b0;
            if (v < I) x = in[v];
            else if (v < I + N) x = m_q[v - I];
            idx |= int'(x) << j;
        end
        return cbit(b*BB + K*S + 1 + idx);
    endfunction

    function automatic int exp_out();
        int v = 0;
        if (!m_run) return 0;
        for (int b = 0; b < N; b++) begin
            bit o = (field(b, K*S, 1) != 0) ? lut_eval(b) : m_q[b];
            v |= int'(o) << b;
        end
        return v;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            hist.delete();
            m_run = 0; m_shift = 0; m_err = 0; m_so = 0; m_cnt = 0; m_q = '0;
        end else if (scan_en) begin
            m_cnt   = m_shift ? ((m_cnt < CB + 1) ? m_cnt + 1 : m_cnt) : 1;
            m_shift = 1;
            m_run   = 0;
            m_so    = cbit(CB - 1);
            hist.push_front(scan_in);
            if (hist.size() > CB) void'(hist.pop_back());
            m_q = '0;
        end else if (m_shift) begin
            m_shift = 0;
            if (m_cnt == CB) begin m_run = 1; m_err = 0; end
            else m_err = 1;
            m_cnt = 0;
        end else if (m_run && ce) begin
            for (int b = 0; b < N; b++) m_nq[b] = lut_eval(b);
            m_q = m_nq;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("model_out", int'(out), exp_out());
            check("model_cfg_done", int'(cfg_done), int'(m_run));
            check("model_cfg_err", int'(cfg_err), int'(m_err));
            check("model_scan_out", int'(scan_out), int'(m_so));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [255:0]  cfgv;
    logic          so_log[256];

    task automatic put(input int b, input int off, input int w, input int val);
        for (int i = 0; i < w; i++) cfgv[b*BB + off + i] = val[i];
    endtask

    task automatic shift_seq(input logic [255:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            scan_en = 1'b1;
            scan_in = bits[n-1-i];
            tick();
            so_log[i] = scan_out;
        end
        scan_en = 1'b0;
        scan_in = 1'b0;
    endtask

    task automatic run_random(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            in = I'($urandom);
            ce = 1'($urandom_range(0, 1));
            tick();
        end
    endtask

    logic [255:0] cfg_a, bits140;
    int           len;

    initial begin
        rst = 1'b1; scan_en = 1'b0; scan_in = 1'b0; ce = 1'b0; in = '0;
        tick();
        chk_on = 1;
        tick();
        rst = 1'b0;
        #1;
        check("rst_out", int'(out), 0);
        check("rst_cfg_done", int'(cfg_done), 0);
        check("rst_cfg_err", int'(cfg_err), 0);
        check("rst_scan_out", int'(scan_out), 0);

        // BLE0 AND4, BLE1 toggle via own q, BLE2 constant 1, BLE3 random.
        cfgv = '0;
        for (int j = 0; j < K; j++) put(0, j*S, S, j);
        put(0, K*S, 1, 1);
        put(0, K*S+1, 16, 16'h8000);
        put(1, 0, S, 11);
        for (int j = 1; j < K; j++) put(1, j*S, S, 15);
        put(1, K*S, 1, 0);
        put(1, K*S+1, 16, 16'h5555);
        for (int j = 0; j < K; j++) put(2, j*S, S, 15);
        put(2, K*S, 1, 1);
        put(2, K*S+1, 16, 16'h0001);
        for (int j = 0; j < K; j++) put(3, j*S, S, $urandom_range(0, 13));
        put(3, K*S, 1, $urandom_range(0, 1));
        put(3, K*S+1, 16, $urandom_range(0, 65535));
        cfg_a = cfgv;

        shift_seq(cfg_a, CB);
        tick();
        ce = 1'b0;
        in = I'(4'hF);
        #1;
        check("load_cfg_done", int'(cfg_done), 1);
        check("and4_F", int'(out[0]), 1);
        check("const1", int'(out[2]), 1);
        check("toggle_init", int'(out[1]), 0);
        in = I'(4'hE);
        #1;
        check("and4_E", int'(out[0]), 0);

        ce = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("toggle_ce1", int'(out[1]), k % 2);
        end
        ce = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("toggle_ce0_hold", int'(out[1]), 0);
        end

        run_random(150);

        ce = 1'b0;
        shift_seq(cfg_a, CB - 1);
        tick();
        #1;
        check("short_cfg_err", int'(cfg_err), 1);
        check("short_cfg_done", int'(cfg_done), 0);
        check("short_out", int'(out), 0);

        shift_seq(cfg_a, CB);
        tick();
        #1;
        check("reload_cfg_err", int'(cfg_err), 0);
        check("reload_cfg_done", int'(cfg_done), 1);
        run_random(40);

        for (int i = 0; i < 256; i++) bits140[i] = 1'($urandom_range(0, 1));
        shift_seq(bits140, 140);
        check("so_first_old", int'(so_log[0]), int'(cfg_a[CB-1]));
        check("so_delay_first", int'(so_log[132]), int'(bits140[139]));
        check("so_delay_last", int'(so_log[139]), int'(bits140[132]));
        tick();
        #1;
        check("long_cfg_err", int'(cfg_err), 1);
        check("long_cfg_done", int'(cfg_done), 0);

        for (int i = 0; i < 60; i++) begin
            scan_en = 1'b1;
            scan_in = 1'($urandom_range(0, 1));
            tick();
        end
        rst = 1'b1;
        ce  = 1'b1;
        tick();
        #1;
        check("midrst_cfg_done", int'(cfg_done), 0);
        check("midrst_cfg_err", int'(cfg_err), 0);
        check("midrst_out", int'(out), 0);
        check("midrst_scan_out", int'(scan_out), 0);
        rst = 1'b0; scan_en = 1'b0; ce = 1'b0;
        tick();
        check("midrst_err_stays0", int'(cfg_err), 0);

        cfgv = '0;
        for (int b = 0; b < N; b++) begin
            for (int j = 0; j < K; j++) put(b, j*S, S, 15);
            put(b, K*S, 1, 1);
            put(b, K*S+1, 16, 16'h0001);
        end
        shift_seq(cfgv, CB);
        tick();
        for (int k = 0; k < 3; k++) begin
            in = I'($urandom);
            #1;
            check("sel15_const", int'(out), 15);
            tick();
        end

        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < 256; i++) cfgv[i] = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 2) == 0) ? $urandom_range(128, 136) : CB;
            shift_seq(cfgv, len);
            run_random(60);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
